clock_route_gate_array: RTL
===========================

# clock_route_gate_array

Multi-channel clock gate controller. It gates `NUM_CH` copies of one root clock, one per channel. Each channel has an independent four-phase asynchronous enable/acknowledge handshake, a programmable settle time and a global test override. It is the parametrised successor of the single-channel hard-macro gate and sits at the clock-route level, between the power/clock manager (requesters) and the downstream clock domains.

## Interface
Parameters:
- `NUM_CH`, 4: number of gated channels (1..32).
- `SYNC_STAGES`, 2: flops in each enable synchroniser (2..4).
- `SETTLE_CYCLES`, 4: cycles held in WAKE/DRAIN before ack changes (1..255).
- `STAGGER_CYCLES`, 8: minimum spacing between channel turn-ons when staggering is compiled in (1..255).

Ports:
- `clock` in 1: root clock; also the source of every gated output.
- `async_reset` in 1: asynchronous, active-high reset.
- `async_enable` in `NUM_CH`: per-channel request, asynchronous to `clock`.
- `async_enable_ack` out `NUM_CH`: per-channel acknowledge, registered.
- `async_test_en` in 1: forces every gated clock to pass; ignored by the FSMs.
- `clock_route_path_out` out `NUM_CH`: gated clocks.
- `control_path_enable` out `NUM_CH`: registered gate enable per channel, for observability.

## Operation
- Each `async_enable[i]` is synchronised through `SYNC_STAGES` flops, giving `en_s[i]`.
- Per-channel FSM states:
  - OFF: enable 0, ack 0.
  - WAKE: enable 1, ack 0, settle counter running.
  - ON: enable 1, ack 1.
  - DRAIN: enable 0, ack 1, settle counter running.
- Transitions:
  - OFF→WAKE when `en_s` is 1 and the channel is granted.
  - WAKE→ON when the counter reaches `SETTLE_CYCLES-1`.
  - ON→DRAIN when `en_s` is 0.
  - DRAIN→OFF when the counter reaches `SETTLE_CYCLES-1`.
- WAKE and DRAIN are never aborted. An enable change mid-transition is acted on only after ON or OFF is reached.
- Four-phase rule: the requester changes `async_enable[i]` only when `async_enable_ack[i]` equals it. A violation is tolerated (the FSM follows the above) but is not a supported protocol.
- Settle counter: 8 bits, cleared on every state entry.
- Gating uses a latch-based ICG: the enable latch is transparent while `clock` is low, and the output is `clock & (latch | async_test_en)`. This gives a glitch-free output with no truncated pulses.
- Channels are fully independent. Simultaneous requests on all channels are served in parallel unless staggering is enabled.

## Timing
- Reset values: all FSMs OFF, `async_enable_ack`=0, `control_path_enable`=0, synchronisers 0, `clock_route_path_out` held low (unless `async_test_en`=1).
- Edge 0 is the first `clock` edge that samples `async_enable[i]`=1.
  - `en_s` is high after `SYNC_STAGES` edges.
  - WAKE (`control_path_enable`=1) is entered on the next edge.
  - ack rises `SETTLE_CYCLES` edges later.
  - Total: `SYNC_STAGES+1+SETTLE_CYCLES` edges (7 at defaults).
- The first full gated pulse is the high phase following the edge at which `control_path_enable` rises.
- Disable is symmetric: ack falls `SYNC_STAGES+1+SETTLE_CYCLES` edges after the low is first sampled. The gated clock stops at the edge entering DRAIN.
- `async_reset` asserted mid-operation: immediately OFF, ack 0, gated clock low at the next low phase. No drain is performed.
- `async_test_en` acts combinationally on the outputs and does not change FSM timing.

## Configuration
- `CLOCK_GATE_STAGGER_EN` defined:
  - OFF→WAKE requires a grant from a round-robin arbiter. The arbiter grants the lowest pending index after the last-granted one.
  - At most one grant per `STAGGER_CYCLES` edges, timed by an 8-bit down-counter that reloads on each grant.
  - Turn-offs are never staggered.
- `CLOCK_GATE_STAGGER_EN` undefined: grant is tied to 1 for every channel, and no arbiter or counter is present.

## Structure
- Package `clock_gate_pkg`:
  - `clock_gate_state_t` enum {OFF, WAKE, ON, DRAIN}.
  - `CLOCK_GATE_CNT_W`=8.
  - Default parameter constants.
- Sub-module `clock_gate_channel_fsm`: synchroniser, FSM and settle counter for one channel. It is instantiated `NUM_CH` times via generate.
- The ICG per channel reuses the existing `clock_route_path_gate`.
- The top level holds the optional stagger arbiter.

## Test plan
Defaults apply: `NUM_CH`=4, `SYNC_STAGES`=2, `SETTLE_CYCLES`=4, `STAGGER_CYCLES`=8.
- Reset: assert `async_reset` mid-ON on ch0 → ack[0] and `control_path_enable`[0] are 0 immediately; `clock_route_path_out`[0] is low within half a cycle.
- Single wake: `async_enable`[1] 0→1 → `control_path_enable`[1] rises at edge 3, ack[1] at edge 7; first gated pulse in cycle 4; other channels stay low.
- Single sleep: drop `async_enable`[1] from ON → gating stops at edge 3, ack[1] falls at edge 7.
- Mid-transition change: drop enable[2] at edge 4 of its wake → ack[2] still rises at edge 7, then DRAIN follows, ack[2]=0 by edge 14.
- Test override: `async_test_en`=1 with all channels OFF → all 4 outputs toggle with `clock`; acks remain 0.
- Stagger (macro defined): raise all 4 enables together → `control_path_enable` rises on ch0,1,2,3 at edges 3, 11, 19, 27, and the acks 4 edges after each. Without the macro, all four rise at edge 3.

Source files
------------

// File: rtl/clock_gate_pkg.sv
// -----------------------------------------------------------------------------
// clock_gate_pkg
// Shared types and default constants for the clock-route gate array.
//   clock_gate_state_t : per-channel gate FSM state {OFF, WAKE, ON, DRAIN}
//   clock_gate_cnt_t   : settle / stagger counter type (CLOCK_GATE_CNT_W bits)
//   CLOCK_GATE_*_DEF   : default values for the top-level parameters
// -----------------------------------------------------------------------------
package clock_gate_pkg;

    localparam int unsigned CLOCK_GATE_CNT_W = 8;

    localparam int unsigned CLOCK_GATE_NUM_CH_DEF         = 4;
    localparam int unsigned CLOCK_GATE_SYNC_STAGES_DEF    = 2;
    localparam int unsigned CLOCK_GATE_SETTLE_CYCLES_DEF  = 4;
    localparam int unsigned CLOCK_GATE_STAGGER_CYCLES_DEF = 8;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        WAKE  = 2'd1,
        ON    = 2'd2,
        DRAIN = 2'd3
    } clock_gate_state_t;

    typedef logic [CLOCK_GATE_CNT_W-1:0] clock_gate_cnt_t;

endpackage

// File: rtl/clock_gate_channel_fsm.sv
// -----------------------------------------------------------------------------
// clock_gate_channel_fsm
// Enable synchroniser, OFF/WAKE/ON/DRAIN FSM and settle counter for one
// gated channel.
//   clock        in  : root clock
//   async_reset  in  : asynchronous active-high reset
//   async_enable in  : channel request, asynchronous to clock
//   grant        in  : permission to leave OFF (tied high when not staggered)
//   req          out : channel is OFF and its synchronised request is high
//   enable       out : registered gate enable (high in WAKE and ON)
//   ack          out : registered acknowledge (high in ON and DRAIN)
// -----------------------------------------------------------------------------
module clock_gate_channel_fsm
    import clock_gate_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = CLOCK_GATE_SYNC_STAGES_DEF,
    parameter int unsigned SETTLE_CYCLES = CLOCK_GATE_SETTLE_CYCLES_DEF
) (
    input  logic clock,
    input  logic async_reset,
    input  logic async_enable,
    input  logic grant,
    output logic req,
    output logic enable,
    output logic ack
);

    localparam clock_gate_cnt_t SETTLE_LAST = CLOCK_GATE_CNT_W'(SETTLE_CYCLES - 1);

    // sync_q[0] is the capture flop that first samples the request (edge 0);
    // the SYNC_STAGES flops behind it make en_s rise SYNC_STAGES edges later,
    // so the FSM reacts on edge SYNC_STAGES+1.
    logic [SYNC_STAGES:0] sync_q;
    logic                 en_s;

    clock_gate_state_t state;
    clock_gate_cnt_t   cnt;

    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-1:0], async_enable};
        end
    end

    assign en_s = sync_q[SYNC_STAGES];
    assign req  = (state == OFF) && en_s;

    // WAKE and DRAIN always run to completion; the request is only looked at
    // again once ON or OFF has been reached.
    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            state  <= OFF;
            cnt    <= '0;
            enable <= 1'b0;
            ack    <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    if (en_s && grant) begin
                        state  <= WAKE;
                        cnt    <= '0;
                        enable <= 1'b1;
                    end
                end
                WAKE: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= ON;
                        cnt   <= '0;
                        ack   <= 1'b1;
                    end else begin
                        cnt <= cnt + clock_gate_cnt_t'(1);
                    end
                end
                ON: begin
                    if (!en_s) begin
                        state  <= DRAIN;
                        cnt    <= '0;
                        enable <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= OFF;
                        cnt   <= '0;
                        ack   <= 1'b0;
                    end else begin
                        cnt <= cnt + clock_gate_cnt_t'(1);
                    end
                end
                default: begin
                    state  <= OFF;
                    cnt    <= '0;
                    enable <= 1'b0;
                    ack    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/clock_route_path_gate.sv
// -----------------------------------------------------------------------------
// clock_route_path_gate
// Latch-based integrated clock gate for one clock route.
//   clock       in  : root clock
//   enable      in  : gate enable, must be stable around the rising edge
//   test_en     in  : forces the clock through
//   gated_clock out : clock & (latched enable | test_en)
// The enable latch is transparent while clock is low, so a change of enable
// can only take effect at the start of a high phase: no truncated pulses.
// -----------------------------------------------------------------------------
module clock_route_path_gate (
    input  logic clock,
    input  logic enable,
    input  logic test_en,
    output logic gated_clock
);

    logic en_latch;

    always_latch begin
        if (!clock) begin
            en_latch <= enable;
        end
    end

    assign gated_clock = clock & (en_latch | test_en);

endmodule

// File: rtl/clock_route_gate_array.sv
// -----------------------------------------------------------------------------
// clock_route_gate_array
// NUM_CH independent clock gates on one root clock, each with a four-phase
// enable/acknowledge handshake and a programmable settle time.
//   clock               in  : root clock, source of every gated output
//   async_reset         in  : asynchronous active-high reset
//   async_enable        in  : per-channel request [NUM_CH]
//   async_enable_ack    out : per-channel registered acknowledge [NUM_CH]
//   async_test_en       in  : forces every gated clock through (FSMs unaffected)
//   clock_route_path_out out: gated clocks [NUM_CH]
//   control_path_enable out : registered gate enable per channel [NUM_CH]
// Build option: CLOCK_GATE_STAGGER_EN adds a round-robin arbiter that spaces
// channel turn-ons by at least STAGGER_CYCLES edges. Turn-offs are immediate.
// -----------------------------------------------------------------------------
module clock_route_gate_array
    import clock_gate_pkg::*;
#(
    parameter int unsigned NUM_CH         = CLOCK_GATE_NUM_CH_DEF,
    parameter int unsigned SYNC_STAGES    = CLOCK_GATE_SYNC_STAGES_DEF,
    parameter int unsigned SETTLE_CYCLES  = CLOCK_GATE_SETTLE_CYCLES_DEF,
    parameter int unsigned STAGGER_CYCLES = CLOCK_GATE_STAGGER_CYCLES_DEF
) (
    input  logic              clock,
    input  logic              async_reset,
    input  logic [NUM_CH-1:0] async_enable,
    output logic [NUM_CH-1:0] async_enable_ack,
    input  logic              async_test_en,
    output logic [NUM_CH-1:0] clock_route_path_out,
    output logic [NUM_CH-1:0] control_path_enable
);

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;

`ifdef CLOCK_GATE_STAGGER_EN
    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    clock_gate_cnt_t    stagger_cnt;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               fire;

    // Round-robin: scan from the channel after the last one granted, wrap.
    always_comb begin
        int unsigned idx;
        pick_idx   = '0;
        pick_valid = 1'b0;
        idx        = 0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = (int unsigned'(last_grant) + k) % NUM_CH;
            if (!pick_valid && req[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(idx);
            end
        end
    end

    assign fire = pick_valid && (stagger_cnt == '0);

    always_comb begin
        grant = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            grant[k] = fire && (IDX_W'(k) == pick_idx);
        end
    end

    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            stagger_cnt <= '0;
            last_grant  <= IDX_W'(NUM_CH - 1);
        end else if (fire) begin
            stagger_cnt <= CLOCK_GATE_CNT_W'(STAGGER_CYCLES - 1);
            last_grant  <= pick_idx;
        end else if (stagger_cnt != '0) begin
            stagger_cnt <= stagger_cnt - clock_gate_cnt_t'(1);
        end
    end
`else
    logic unused_stagger;

    assign grant          = '1;
    assign unused_stagger = ^{req, CLOCK_GATE_CNT_W'(STAGGER_CYCLES)};
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clock_gate_channel_fsm #(
            .SYNC_STAGES   (SYNC_STAGES),
            .SETTLE_CYCLES (SETTLE_CYCLES)
        ) u_fsm (
            .clock        (clock),
            .async_reset  (async_reset),
            .async_enable (async_enable[i]),
            .grant        (grant[i]),
            .req          (req[i]),
            .enable       (control_path_enable[i]),
            .ack          (async_enable_ack[i])
        );

        clock_route_path_gate u_icg (
            .clock       (clock),
            .enable      (control_path_enable[i]),
            .test_en     (async_test_en),
            .gated_clock (clock_route_path_out[i])
        );
    end

endmodule
